imem_loader: RTL and testbench

IMEM_LOADER -- requirements
Module: imem_loader

---
 rtl/imem_loader.sv | 142 ++++++++++++++
 tb/tb_imem_loader.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/imem_loader.sv
// Serial program loader: assembles MSB-first bytes into 32-bit words and writes them to instruction memory while stalling the CPU.
// Optional checksum byte after the end marker is enabled with `define IMEM_LOADER_CHECKSUM_EN.
module imem_loader #(
  parameter int unsigned MEM_DEPTH = 256,
  parameter logic [31:0] END_WORD  = 32'hFFFF_FFFF
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        load_start,
  input  logic                        byte_valid,
  input  logic [7:0]                  byte_data,
  input  logic [31:0]                 fetch_pc,
  output logic [31:0]                 imem_addr,
  output logic                        imem_we,
  output logic [31:0]                 imem_wdata,
  output logic                        cpu_stall,
  output logic                        load_done,
  output logic                        load_err,
  output logic [$clog2(MEM_DEPTH):0]  word_count
);

  localparam int unsigned    WCW        = $clog2(MEM_DEPTH) + 1;
  localparam logic [WCW-1:0] LAST_COUNT = WCW'(MEM_DEPTH);

`ifdef IMEM_LOADER_CHECKSUM_EN
  typedef enum logic [2:0] {IDLE, RECV, WRITE, DONE, CHECK} state_e;
`else
  typedef enum logic [2:0] {IDLE, RECV, WRITE, DONE} state_e;
`endif

  state_e         state_q, state_d;
  logic [31:0]    word_q, word_d;
  logic [1:0]     byte_cnt_q, byte_cnt_d;
  logic [WCW-1:0] word_count_q, word_count_d;
  logic           load_done_q, load_done_d;
  logic           load_err_q, load_err_d;
`ifdef IMEM_LOADER_CHECKSUM_EN
  logic [7:0]     xor_q, xor_d;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      word_q       <= '0;
      byte_cnt_q   <= '0;
      word_count_q <= '0;
      load_done_q  <= 1'b0;
      load_err_q   <= 1'b0;
`ifdef IMEM_LOADER_CHECKSUM_EN
      xor_q        <= '0;
`endif
    end else begin
      state_q      <= state_d;
      word_q       <= word_d;
      byte_cnt_q   <= byte_cnt_d;
      word_count_q <= word_count_d;
      load_done_q  <= load_done_d;
      load_err_q   <= load_err_d;
`ifdef IMEM_LOADER_CHECKSUM_EN
      xor_q        <= xor_d;
`endif
    end
  end

  always_comb begin
    state_d      = state_q;
    word_d       = word_q;
    byte_cnt_d   = byte_cnt_q;
    word_count_d = word_count_q;
    load_done_d  = load_done_q;
    load_err_d   = load_err_q;
`ifdef IMEM_LOADER_CHECKSUM_EN
    xor_d        = xor_q;
`endif
    imem_we      = 1'b0;
    cpu_stall    = 1'b1;
    imem_addr    = 32'({word_count_q, 2'b00});

    case (state_q)
      IDLE: begin
        imem_addr = fetch_pc;
        cpu_stall = 1'b0;
        if (load_start) begin
          state_d      = RECV;
          load_done_d  = 1'b0;
          load_err_d   = 1'b0;
          word_count_d = '0;
          byte_cnt_d   = '0;
`ifdef IMEM_LOADER_CHECKSUM_EN
          xor_d        = '0;
`endif
        end
      end
      RECV: begin
        if (byte_valid) begin
          word_d     = {word_q[23:0], byte_data};
          byte_cnt_d = byte_cnt_q + 2'd1;
`ifdef IMEM_LOADER_CHECKSUM_EN
          xor_d      = xor_q ^ byte_data;
`endif
          if (byte_cnt_q == 2'd3) state_d = WRITE;
        end
      end
      WRITE: begin
        imem_we      = 1'b1;
        word_count_d = word_count_q + 1'b1;
        // The end marker wins over the depth limit when it lands in the last slot.
        if (word_q == END_WORD) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
          state_d = CHECK;
`else
          state_d = DONE;
`endif
        end else if (word_count_d == LAST_COUNT) begin
          load_err_d = 1'b1;
          state_d    = DONE;
        end else begin
          state_d = RECV;
        end
      end
`ifdef IMEM_LOADER_CHECKSUM_EN
      CHECK: begin
        if (byte_valid) begin
          if (byte_data != xor_q) load_err_d = 1'b1;
          state_d = DONE;
        end
      end
`endif
      DONE: begin
        load_done_d = 1'b1;
        state_d     = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign imem_wdata = word_q;
  assign load_done  = load_done_q;
  assign load_err   = load_err_q;
  assign word_count = word_count_q;

endmodule

// File: tb/tb_imem_loader.sv
// Scoreboard bench for imem_loader: expected memory writes are queued by the stimulus and checked by a write monitor.
module tb_imem_loader;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        load_start;
  logic        byte_valid;
  logic [7:0]  byte_data;
  logic [31:0] fetch_pc;
  logic [31:0] imem_addr;
  logic        imem_we;
  logic [31:0] imem_wdata;
  logic        cpu_stall;
  logic        load_done;
  logic        load_err;
  logic [2:0]  word_count;

  int checks = 0;
  int errors = 0;
  logic [63:0] exp_q[$];
  logic [31:0] exp_addr;

  imem_loader #(.MEM_DEPTH(4), .END_WORD(32'hFFFF_FFFF)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .load_start (load_start),
    .byte_valid (byte_valid),
    .byte_data  (byte_data),
    .fetch_pc   (fetch_pc),
    .imem_addr  (imem_addr),
    .imem_we    (imem_we),
    .imem_wdata (imem_wdata),
    .cpu_stall  (cpu_stall),
    .load_done  (load_done),
    .load_err   (load_err),
    .word_count (word_count)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Write monitor: every strobe must match the oldest queued write.
  always @(negedge clk) begin
    if (rst_n === 1'b1 && imem_we === 1'b1) begin
      logic [63:0] e;
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_write: got addr 0x%08h data 0x%08h expected no write", imem_addr, imem_wdata);
      end else begin
        e = exp_q.pop_front();
        chk("write_addr", imem_addr, e[63:32]);
        chk("write_data", imem_wdata, e[31:0]);
      end
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic stall_gap(input int gap);
    repeat (gap) begin
      chk("stall_gap", 32'(cpu_stall), 32'd1);
      cyc();
    end
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap, input logic ls);
    byte_valid = 1'b1;
    byte_data  = b;
    load_start = ls;
    cyc();
    byte_valid = 1'b0;
    load_start = 1'b0;
    stall_gap(gap);
  endtask

  // Four bytes MSB-first, then a junk byte during the write cycle that must be dropped.
  task automatic send_word(input logic [31:0] w, input int gap, input logic ls_first);
    logic [31:0] wv;
    wv = w;
    exp_q.push_back({exp_addr, wv});
    exp_addr += 32'd4;
    for (int i = 0; i < 4; i++)
      send_byte(wv[31-8*i -: 8], (i == 3) ? 0 : gap, ls_first && (i == 0));
    chk("we_latency", 32'(imem_we), 32'd1);
    send_byte(8'hAA, 0, 1'b0);
  endtask

  // load_start with a simultaneous byte: the byte must be dropped.
  task automatic start_load();
    load_start = 1'b1;
    byte_valid = 1'b1;
    byte_data  = 8'h55;
    cyc();
    load_start = 1'b0;
    byte_valid = 1'b0;
    exp_addr   = '0;
  endtask

  task automatic wait_done(input logic [31:0] wc, input logic [31:0] err);
    int n;
    n = 0;
    while (load_done !== 1'b1 && n < 20) begin
      cyc();
      n++;
    end
    chk("done_flag", 32'(load_done), 32'd1);
    chk("word_count", 32'(word_count), wc);
    chk("load_err", 32'(load_err), err);
    chk("stall_after", 32'(cpu_stall), 32'd0);
    chk("pending_writes", 32'(exp_q.size()), 32'd0);
  endtask

  task automatic basic_stream(input logic [7:0] cs);
    start_load();
    send_word(32'h2008_0005, 0, 1'b0);
    send_word(32'hFFFF_FFFF, 0, 1'b1);
`ifdef IMEM_LOADER_CHECKSUM_EN
    send_byte(cs, 0, 1'b0);
`else
    if (cs != 8'h00) cyc();
`endif
  endtask

  initial begin
    rst_n      = 1'b0;
    load_start = 1'b0;
    byte_valid = 1'b0;
    byte_data  = '0;
    fetch_pc   = 32'h0000_0010;
    exp_addr   = '0;
    #12;
    chk("rst_we", 32'(imem_we), 32'd0);
    chk("rst_wdata", imem_wdata, 32'd0);
    chk("rst_stall", 32'(cpu_stall), 32'd0);
    chk("rst_done", 32'(load_done), 32'd0);
    chk("rst_err", 32'(load_err), 32'd0);
    chk("rst_wc", 32'(word_count), 32'd0);
    cyc();
    rst_n = 1'b1;
    cyc();
    chk("idle_addr", imem_addr, 32'h0000_0010);
    chk("idle_stall", 32'(cpu_stall), 32'd0);
    chk("idle_we", 32'(imem_we), 32'd0);
    fetch_pc = 32'h0000_1234;
    #1;
    chk("idle_addr2", imem_addr, 32'h0000_1234);

    // Basic load; load_start in RECV must be ignored.
    basic_stream(8'h2D);
    wait_done(32'd2, 32'd0);

    // Gapped bytes.
    start_load();
    send_word(32'h2008_0005, 3, 1'b0);
    stall_gap(3);
    send_word(32'hFFFF_FFFF, 3, 1'b0);
`ifdef IMEM_LOADER_CHECKSUM_EN
    send_byte(8'h2D, 0, 1'b0);
`endif
    wait_done(32'd2, 32'd0);

    // Overflow at depth 4.
    start_load();
    send_word(32'h1111_1111, 0, 1'b0);
    send_word(32'h2222_2222, 0, 1'b0);
    send_word(32'h3333_3333, 0, 1'b0);
    send_word(32'h4444_4444, 0, 1'b0);
    wait_done(32'd4, 32'd1);

    // Reset after six bytes.
    start_load();
    send_word(32'h2008_0005, 0, 1'b0);
    send_byte(8'h12, 0, 1'b0);
    send_byte(8'h34, 0, 1'b0);
    rst_n = 1'b0;
    #1;
    chk("midrst_we", 32'(imem_we), 32'd0);
    chk("midrst_wdata", imem_wdata, 32'd0);
    chk("midrst_stall", 32'(cpu_stall), 32'd0);
    chk("midrst_done", 32'(load_done), 32'd0);
    chk("midrst_err", 32'(load_err), 32'd0);
    chk("midrst_wc", 32'(word_count), 32'd0);
    chk("midrst_addr", imem_addr, 32'h0000_1234);
    cyc();
    rst_n = 1'b1;
    cyc();
    chk("postrst_addr", imem_addr, 32'h0000_1234);
    chk("postrst_stall", 32'(cpu_stall), 32'd0);
    basic_stream(8'h2D);
    wait_done(32'd2, 32'd0);

`ifdef IMEM_LOADER_CHECKSUM_EN
    basic_stream(8'h00);
    wait_done(32'd2, 32'd1);
`endif

    repeat (3) cyc();
    chk("final_pending", 32'(exp_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
